// File: rtl/tof_peak_detector.sv
`timescale 1ns/1ps
// Time-of-flight echo peak detector: skips blank_len ring-down samples after start,
// then finds the largest magnitude >= threshold within window_len samples.
module tof_peak_detector #(
  parameter int IDX_W = 16,
  parameter int MAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] blank_len,
  input  logic [IDX_W-1:0] window_len,
  input  logic [MAG_W-1:0] threshold,
  input  logic             mag_valid,
  input  logic [MAG_W-1:0] magnitude,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] peak_index,
  output logic [MAG_W-1:0] peak_mag,
  output logic [MAG_W-1:0] peak_prev,
  output logic [MAG_W-1:0] peak_next,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_SEARCH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] blank_len_q, blank_len_d;
  logic [IDX_W-1:0] window_len_q, window_len_d;
  logic [MAG_W-1:0] threshold_q, threshold_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [MAG_W-1:0] last_q, last_d;
  logic             found_q, found_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [MAG_W-1:0] prev_q, prev_d;
  logic [MAG_W-1:0] next_q, next_d;
  logic             pend_q, pend_d;
  logic             candidate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      blank_len_q  <= '0;
      window_len_q <= '0;
      threshold_q  <= '0;
      cnt_q        <= '0;
      last_q       <= '0;
      found_q      <= 1'b0;
      idx_q        <= '0;
      mag_q        <= '0;
      prev_q       <= '0;
      next_q       <= '0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      blank_len_q  <= blank_len_d;
      window_len_q <= window_len_d;
      threshold_q  <= threshold_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      found_q      <= found_d;
      idx_q        <= idx_d;
      mag_q        <= mag_d;
      prev_q       <= prev_d;
      next_q       <= next_d;
      pend_q       <= pend_d;
    end
  end

  // Strict greater-than against the held peak keeps the earliest of equal peaks.
  assign candidate = (magnitude >= threshold_q) && (!found_q || (magnitude > mag_q));

  always_comb begin
    state_d      = state_q;
    blank_len_d  = blank_len_q;
    window_len_d = window_len_q;
    threshold_d  = threshold_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    found_d      = found_q;
    idx_d        = idx_q;
    mag_d        = mag_q;
    prev_d       = prev_q;
    next_d       = next_q;
    pend_d       = pend_q;

    if (start) begin
      blank_len_d  = blank_len;
      window_len_d = window_len;
      threshold_d  = threshold;
      cnt_d        = '0;
      last_d       = '0;
      found_d      = 1'b0;
      idx_d        = '0;
      mag_d        = '0;
      prev_d       = '0;
      next_d       = '0;
      pend_d       = 1'b0;
      state_d      = (blank_len != '0) ? S_BLANK : S_SEARCH;
    end else begin
      case (state_q)
        S_BLANK: begin
          if (mag_valid) begin
            last_d = magnitude;
            if (cnt_q == blank_len_q - IDX_W'(1)) begin
              cnt_d   = '0;
              state_d = S_SEARCH;
            end else begin
              cnt_d = cnt_q + IDX_W'(1);
            end
          end
        end
        S_SEARCH: begin
          if (window_len_q == '0) begin
            state_d = S_DONE;
          end else if (mag_valid) begin
            last_d = magnitude;
            cnt_d  = cnt_q + IDX_W'(1);
            if (candidate) begin
              found_d = 1'b1;
              idx_d   = cnt_q;
              mag_d   = magnitude;
              prev_d  = last_q;
              next_d  = '0;
              pend_d  = 1'b1;
            end else if (pend_q) begin
              next_d = magnitude;
              pend_d = 1'b0;
            end
            if (cnt_q == window_len_q - IDX_W'(1)) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q == S_BLANK) || (state_q == S_SEARCH);
  assign done       = (state_q == S_DONE);
  assign found      = found_q;
  assign peak_index = idx_q;
  assign peak_mag   = mag_q;
  assign peak_prev  = prev_q;
  assign peak_next  = next_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tof_peak_detector.sv
`timescale 1ns/1ps
// Bench for tof_peak_detector: table-driven measurements, randomised measurements
// against a reference model, abort/restart and asynchronous-reset sequences.
module tb_tof_peak_detector;

  localparam int IDX_W = 16;
  localparam int MAG_W = 32;
  localparam int RES_W = 1 + IDX_W + 3 * MAG_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [IDX_W-1:0] blank_len = '0;
  logic [IDX_W-1:0] window_len = '0;
  logic [MAG_W-1:0] threshold = '0;
  logic             mag_valid = 1'b0;
  logic [MAG_W-1:0] magnitude = '0;
  logic             busy, done, found;
  logic [IDX_W-1:0] peak_index;
  logic [MAG_W-1:0] peak_mag, peak_prev, peak_next;
  logic [1:0]       dbg_state;

  tof_peak_detector #(.IDX_W(IDX_W), .MAG_W(MAG_W)) dut (
    .clk(clk), .rst(rst), .start(start), .blank_len(blank_len),
    .window_len(window_len), .threshold(threshold), .mag_valid(mag_valid),
    .magnitude(magnitude), .busy(busy), .done(done), .found(found),
    .peak_index(peak_index), .peak_mag(peak_mag), .peak_prev(peak_prev),
    .peak_next(peak_next), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int dones_exp = 0;
  logic [RES_W-1:0] exp_q[$];
  logic [MAG_W-1:0] cur_mags[32];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    int               bl;
    int               wn;
    logic [MAG_W-1:0] thr;
    int               gap;
    logic             f;
    logic [IDX_W-1:0] idx;
    logic [MAG_W-1:0] m;
    logic [MAG_W-1:0] p;
    logic [MAG_W-1:0] n;
  } vec_t;

  vec_t             tbl[6];
  logic [MAG_W-1:0] pool[29];

  task automatic check(input string name, input logic [MAG_W-1:0] act, input logic [MAG_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RES_W-1:0] model(input int bl, input int wn, input logic [MAG_W-1:0] thr);
    logic [MAG_W-1:0] last, pm, pp, pn, m;
    logic [IDX_W-1:0] pi;
    logic             f, pend;
    last = '0; pm = '0; pp = '0; pn = '0; pi = '0; f = 1'b0; pend = 1'b0;
    for (int i = 0; i < bl; i++) last = cur_mags[i];
    for (int j = 0; j < wn; j++) begin
      m = cur_mags[bl + j];
      if (m >= thr && (!f || m > pm)) begin
        f = 1'b1; pi = IDX_W'(j); pm = m; pp = last; pn = '0; pend = 1'b1;
      end else if (pend) begin
        pn = m; pend = 1'b0;
      end
      last = m;
    end
    return {f, pi, pm, pp, pn};
  endfunction

  // driver tasks
  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      mag_valid = 1'b1;
      magnitude = cur_mags[i];
      @(posedge clk); #1;
      mag_valid = 1'b0;
    end
  endtask

  task automatic pulse_start(input int bl, input int wn, input logic [MAG_W-1:0] thr);
    @(posedge clk); #1;
    start = 1'b1;
    blank_len = bl[IDX_W-1:0];
    window_len = wn[IDX_W-1:0];
    threshold = thr;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_result();
    logic [RES_W-1:0] r;
    check("done_pulse", {31'd0, done}, 1);
    check("busy_at_done", {31'd0, busy}, 0);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got done with no expected result");
    end else begin
      r = exp_q.pop_front();
      check("found", {31'd0, found}, {31'd0, r[RES_W-1]});
      check("peak_index", {16'd0, peak_index}, {16'd0, r[RES_W-2 -: IDX_W]});
      check("peak_mag", peak_mag, r[3*MAG_W-1 -: MAG_W]);
      check("peak_prev", peak_prev, r[2*MAG_W-1 -: MAG_W]);
      check("peak_next", peak_next, r[MAG_W-1:0]);
    end
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 0);
    check("idle_after_done", {30'd0, dbg_state}, 0);
  endtask

  task automatic run_vec(input int bl, input int wn, input logic [MAG_W-1:0] thr,
                         input int gap, input logic [RES_W-1:0] exp_res);
    pulse_start(bl, wn, thr);
    exp_q.push_back(exp_res);
    dones_exp++;
    check("busy_after_start", {31'd0, busy}, 1);
    check("found_cleared", {31'd0, found}, 0);
    feed(bl + wn, gap);
    if (wn == 0) begin @(posedge clk); #1; end
    check_result();
  endtask

  initial begin
    int p;
    logic [RES_W-1:0] er;
    int bl, wn, gap;
    logic [MAG_W-1:0] thr;

    pool = '{32'd50, 32'd50, 32'd50, 32'd1, 32'd5, 32'd20, 32'd40, 32'd30, 32'd40, 32'd2, 32'd1,
             32'd10, 32'd20, 32'd30, 32'd40,
             32'd5, 32'd6, 32'd9,
             32'd11, 32'd22,
             32'd70, 32'd60, 32'd80, 32'd80, 32'd90, 32'd10,
             32'd7, 32'hFFFF_FFF0, 32'd3};
    tbl[0] = '{3, 8, 32'd10,  0, 1'b1, 16'd3, 32'd40, 32'd20, 32'd30};
    tbl[1] = '{0, 4, 32'd100, 0, 1'b0, 16'd0, 32'd0,  32'd0,  32'd0};
    tbl[2] = '{0, 3, 32'd0,   2, 1'b1, 16'd2, 32'd9,  32'd6,  32'd0};
    tbl[3] = '{2, 0, 32'd0,   0, 1'b0, 16'd0, 32'd0,  32'd0,  32'd0};
    tbl[4] = '{1, 5, 32'd50,  0, 1'b1, 16'd3, 32'd90, 32'd80, 32'd10};
    tbl[5] = '{0, 3, 32'd5,   1, 1'b1, 16'd1, 32'hFFFF_FFF0, 32'd7, 32'd3};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_found", {31'd0, found}, 0);
    check("rst_index", {16'd0, peak_index}, 0);
    check("rst_mag", peak_mag, 0);
    check("rst_state", {30'd0, dbg_state}, 0);
    rst = 1'b0;

    // IDLE ignores samples
    cur_mags[0] = 32'd77;
    feed(3, 0);
    check("idle_ignores_busy", {31'd0, busy}, 0);
    check("idle_ignores_found", {31'd0, found}, 0);

    p = 0;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < tbl[v].bl + tbl[v].wn; i++) begin
        cur_mags[i] = pool[p];
        p++;
      end
      run_vec(tbl[v].bl, tbl[v].wn, tbl[v].thr, tbl[v].gap,
              {tbl[v].f, tbl[v].idx, tbl[v].m, tbl[v].p, tbl[v].n});
    end

    // randomised measurements against the reference model
    for (int r = 0; r < 8; r++) begin
      bl = $urandom_range(0, 3);
      wn = $urandom_range(1, 10);
      thr = MAG_W'($urandom_range(0, 200));
      gap = $urandom_range(0, 1);
      for (int i = 0; i < bl + wn; i++) cur_mags[i] = MAG_W'($urandom_range(0, 255));
      run_vec(bl, wn, thr, gap, model(bl, wn, thr));
    end

    // abort mid-search, restart with a sample colliding with start
    cur_mags[0] = 32'd100; cur_mags[1] = 32'd5;
    pulse_start(0, 8, 32'd0);
    feed(2, 0);
    check("abort_found_before", {31'd0, found}, 1);
    start = 1'b1; blank_len = 16'd0; window_len = 16'd3; threshold = 32'd0;
    mag_valid = 1'b1; magnitude = 32'd999;
    @(posedge clk); #1;
    start = 1'b0; mag_valid = 1'b0;
    check("abort_found_cleared", {31'd0, found}, 0);
    check("abort_mag_cleared", peak_mag, 0);
    check("abort_busy", {31'd0, busy}, 1);
    exp_q.push_back({1'b1, 16'd1, 32'd7, 32'd1, 32'd3});
    dones_exp++;
    cur_mags[0] = 32'd1; cur_mags[1] = 32'd7; cur_mags[2] = 32'd3;
    feed(3, 0);
    check_result();

    // asynchronous reset during BLANK
    cur_mags[0] = 32'd60; cur_mags[1] = 32'd61;
    pulse_start(5, 4, 32'd0);
    feed(2, 0);
    check("blank_busy", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 0);
    check("async_rst_done", {31'd0, done}, 0);
    check("async_rst_state", {30'd0, dbg_state}, 0);
    check("async_rst_found", {31'd0, found}, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) cur_mags[i] = 32'd500;
    feed(8, 0);
    check("post_rst_busy", {31'd0, busy}, 0);
    check("post_rst_found", {31'd0, found}, 0);

    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt, dones_exp);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
